// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler
// Time-multiplexes a single quadratic integrate-and-fire update datapath
// across N_NEURONS neurons. Each tick sweeps every neuron through
// fetch / evaluate / write-back. Spikes are emitted as valid/ready events,
// and write-back of a firing neuron waits for the consumer to accept the spike.
module qif_neuron_scheduler #(
    parameter int                 N_NEURONS = 4,
    parameter logic signed [7:0]  V_RESET   = -8'sd20,
    parameter logic signed [7:0]  V_TH      = 8'sd50,
    parameter int unsigned        REFRAC    = 2,
    localparam int                AW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [7:0]    cfg_cur,
    input  logic [AW-1:0]        mon_addr,
    output logic signed [7:0]    v_mon,
    output logic                 spike_valid,
    output logic [AW-1:0]        spike_id,
    input  logic                 spike_ready,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;

    // Per-neuron state
    logic signed [7:0] v_mem  [N_NEURONS];
    logic signed [7:0] i_mem  [N_NEURONS];
    logic [2:0]        rc_mem [N_NEURONS];

    // Sweep index and datapath registers
    logic [AW-1:0]     idx;
    logic signed [7:0] v_lat;
    logic signed [7:0] i_lat;
    logic [2:0]        rc_lat;
    logic signed [7:0] v_nx;
    logic [2:0]        rc_nx;
    logic              fire_r;

    // Combinational update results
    logic signed [7:0]  eval_v;
    logic [2:0]         eval_rc;
    logic               eval_fire;
    logic signed [10:0] v_ext;
    logic signed [10:0] q_ext;
    logic signed [10:0] sq;
    logic signed [10:0] i_ext;
    logic signed [10:0] i_q;
    logic signed [10:0] sum;
    logic signed [7:0]  sum_sat;

    logic               wr_en;
    logic               last_idx;

    assign v_mon    = v_mem[mon_addr];
    assign last_idx = (idx == AW'(N_NEURONS - 1));
    // Write-back happens on the first WRITE cycle unless a spike is waiting
    // for acceptance, in which case it happens on the handshake cycle.
    assign wr_en    = (state == S_WRITE) && (!fire_r || spike_ready);

    // QIF update rule on the values latched at FETCH
    always_comb begin
        v_ext     = {{3{v_lat[7]}}, v_lat};
        q_ext     = v_ext >>> 3;
        sq        = q_ext * q_ext;
        i_ext     = {{3{i_lat[7]}}, i_lat};
        i_q       = i_ext >>> 2;
        sum       = v_ext + sq + i_q;
        if (sum > 11'sd127) begin
            sum_sat = 8'sd127;
        end else if (sum < -11'sd128) begin
            sum_sat = -8'sd128;
        end else begin
            sum_sat = sum[7:0];
        end

        eval_v    = V_RESET;
        eval_rc   = rc_lat;
        eval_fire = 1'b0;
        if (rc_lat != 3'd0) begin
            eval_rc = rc_lat - 3'd1;
        end else if (v_lat >= V_TH) begin
            eval_fire = 1'b1;
            eval_rc   = 3'(REFRAC);
        end else begin
            eval_v = sum_sat;
        end
    end

    // Neuron state storage: config writes to I, sweep write-back to V and rc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_NEURONS; k++) begin
                v_mem[k]  <= V_RESET;
                i_mem[k]  <= '0;
                rc_mem[k] <= '0;
            end
        end else begin
            if (cfg_we) begin
                i_mem[cfg_addr] <= cfg_cur;
            end
            if (wr_en) begin
                v_mem[idx]  <= v_nx;
                rc_mem[idx] <= rc_nx;
            end
        end
    end

    // Sweep sequencer with registered status and spike outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            v_lat       <= '0;
            i_lat       <= '0;
            rc_lat      <= '0;
            v_nx        <= '0;
            rc_nx       <= '0;
            fire_r      <= 1'b0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    v_lat  <= v_mem[idx];
                    i_lat  <= i_mem[idx];
                    rc_lat <= rc_mem[idx];
                    state  <= S_EVAL;
                end
                S_EVAL: begin
                    v_nx        <= eval_v;
                    rc_nx       <= eval_rc;
                    fire_r      <= eval_fire;
                    spike_valid <= eval_fire;
                    spike_id    <= idx;
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_en) begin
                        spike_valid <= 1'b0;
                        fire_r      <= 1'b0;
                        if (last_idx) begin
                            sweep_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Self-checking bench for qif_neuron_scheduler: constant vector table,
// directed multi-cycle sequences, and randomized sweeps against a plain
// arithmetic reference model. A second instance with V_TH=127 exercises
// saturation.
module tb_qif_neuron_scheduler;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic signed [7:0] cfg_cur = '0;
    logic [1:0]        mon_addr = '0;
    logic              spike_ready = 1'b0;

    logic signed [7:0] v_mon, v_mon_s;
    logic              spike_valid, spike_valid_s;
    logic [1:0]        spike_id, spike_id_s;
    logic              busy, busy_s, sweep_done, sweep_done_s, overrun, overrun_s;

    qif_neuron_scheduler #(.N_NEURONS(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_cur(cfg_cur), .mon_addr(mon_addr),
        .v_mon(v_mon), .spike_valid(spike_valid), .spike_id(spike_id),
        .spike_ready(spike_ready), .busy(busy), .sweep_done(sweep_done),
        .overrun(overrun)
    );

    qif_neuron_scheduler #(.N_NEURONS(N), .V_TH(8'sd127)) u_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_cur(cfg_cur), .mon_addr(mon_addr),
        .v_mon(v_mon_s), .spike_valid(spike_valid_s), .spike_id(spike_id_s),
        .spike_ready(spike_ready), .busy(busy_s), .sweep_done(sweep_done_s),
        .overrun(overrun_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    int mV[N];
    int mI[N];
    int mrc[N];
    int mspk[$];
    int gspk[$];

    typedef struct {
        bit rst;
        int c[4];
        int v[4];
        int s0;
        int nsp;
        int sid;
    } row_t;
    row_t rows[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_div(input int x, input int d);
        return (x - (((x % d) + d) % d)) / d;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            mV[n] = -20; mI[n] = 0; mrc[n] = 0;
        end
    endfunction

    function automatic void model_sweep();
        int q, t;
        mspk.delete();
        for (int n = 0; n < N; n++) begin
            if (mrc[n] > 0) begin
                mV[n] = -20;
                mrc[n] = mrc[n] - 1;
            end else if (mV[n] >= 50) begin
                mspk.push_back(n);
                mV[n] = -20;
                mrc[n] = 2;
            end else begin
                q = floor_div(mV[n], 8);
                t = mV[n] + q * q + floor_div(mI[n], 4);
                if (t > 127) t = 127;
                if (t < -128) t = -128;
                mV[n] = t;
            end
        end
    endfunction

    function automatic void add_row(input bit rst, input int c0, input int c1, input int c2, input int c3,
                                    input int v0, input int v1, input int v2, input int v3,
                                    input int s0, input int nsp, input int sid);
        row_t r;
        r.rst = rst;
        r.c[0] = c0; r.c[1] = c1; r.c[2] = c2; r.c[3] = c3;
        r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
        r.s0 = s0; r.nsp = nsp; r.sid = sid;
        rows.push_back(r);
    endfunction

    task automatic do_reset();
        tick = 0; cfg_we = 0; spike_ready = 0;
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        step();
        model_reset();
    endtask

    task automatic set_cur(input int a, input int v);
        logic [7:0] b;
        b = v[7:0];
        cfg_we = 1; cfg_addr = a[1:0]; cfg_cur = b;
        step();
        cfg_we = 0;
        mI[a] = v;
    endtask

    task automatic rd(input int a, output int v, output int vs);
        mon_addr = a[1:0];
        #1;
        v = v_mon;
        vs = v_mon_s;
    endtask

    // maxstall == 0: spike_ready held high; otherwise random stall per spike
    task automatic run_sweep(input int maxstall, input bit tick_done,
                             input int cfg_at, input int cfg_a, input int cfg_v);
        int k, stalls, cnt, s;
        logic [7:0] b;
        gspk.delete();
        stalls = 0; cnt = 0; s = 0;
        tick = 1;
        step();
        tick = 0;
        k = 1;
        while (!sweep_done && k < 400) begin
            cfg_we = (k == cfg_at);
            if (k == cfg_at) begin
                b = cfg_v[7:0];
                cfg_addr = cfg_a[1:0];
                cfg_cur = b;
            end
            if (maxstall == 0) begin
                spike_ready = 1;
                if (spike_valid) gspk.push_back(int'(spike_id));
            end else if (spike_valid) begin
                if (cnt == 0) s = $urandom_range(maxstall, 0);
                if (cnt >= s) begin
                    spike_ready = 1;
                    gspk.push_back(int'(spike_id));
                    cnt = 0;
                end else begin
                    spike_ready = 0;
                    stalls++;
                    cnt++;
                end
            end else begin
                spike_ready = 0;
            end
            step();
            k++;
        end
        cfg_we = 0;
        spike_ready = 0;
        chk("sweep_latency", k, 13 + stalls);
        chk("busy_in_done", busy, 1);
        tick = tick_done;
        step();
        tick = 0;
        chk("busy_after_done", busy, 0);
        chk("sweep_done_pulse", sweep_done, 0);
    endtask

    initial begin
        int v, vs;

        // Reset state
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        model_reset();
        for (int a = 0; a < N; a++) begin
            rd(a, v, vs);
            chk("reset_v_mon", v, -20);
        end
        chk("reset_spike_valid", spike_valid, 0);
        chk("reset_spike_id", spike_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sweep_done", sweep_done, 0);
        chk("reset_overrun", overrun, 0);

        // Table: leak sweeps, then spike/refractory scenario (s0 = V_TH=127 instance, neuron 0)
        add_row(1, 0, 0, 0, 0,       -11, -11, -11, -11,  -11, 0, 0);
        add_row(0, 0, 0, 0, 0,        -7,  -7,  -7,  -7,   -7, 0, 0);
        add_row(1, 127, 0, -128, 64,  20, -11, -43,   5,   20, 0, 0);
        add_row(0, 127, 0, -128, 64,  55,  -7, -39,  21,   55, 0, 0);
        add_row(0, 127, 0, -128, 64, -20,  -6, -46,  41,  122, 1, 0);
        add_row(0, 127, 0, -128, 64, -20,  -5, -42,  82,  127, 0, 0);
        add_row(0, 127, 0, -128, 64, -20,  -4, -38, -20,  -20, 1, 3);
        add_row(0, 127, 0, -128, 64,  20,  -3, -45, -20,  -20, 0, 0);

        foreach (rows[r]) begin
            if (rows[r].rst) do_reset();
            for (int a = 0; a < N; a++) set_cur(a, rows[r].c[a]);
            run_sweep(0, 0, 0, 0, 0);
            for (int a = 0; a < N; a++) begin
                rd(a, v, vs);
                chk($sformatf("row%0d_v%0d", r, a), v, rows[r].v[a]);
                if (a == 0) chk($sformatf("row%0d_sat_v0", r), vs, rows[r].s0);
            end
            chk($sformatf("row%0d_nspikes", r), gspk.size(), rows[r].nsp);
            if (rows[r].nsp > 0 && gspk.size() > 0) chk($sformatf("row%0d_spike_id", r), gspk[0], rows[r].sid);
        end

        // Tick in the DONE cycle is ignored and flags overrun
        do_reset();
        run_sweep(0, 1, 0, 0, 0);
        chk("done_tick_overrun", overrun, 1);
        step();
        chk("done_tick_no_sweep", busy, 0);

        // Backpressure on neuron 2
        do_reset();
        set_cur(2, 127);
        run_sweep(0, 0, 0, 0, 0);
        run_sweep(0, 0, 0, 0, 0);
        chk("bp_overrun_clear", overrun, 0);
        mon_addr = 2;
        tick = 1; step(); tick = 0;
        repeat (7) step();
        chk("bp_valid_before", spike_valid, 0);
        step();
        for (int j = 0; j < 10; j++) begin
            chk("bp_valid_held", spike_valid, 1);
            chk("bp_id_held", spike_id, 2);
            chk("bp_busy", busy, 1);
            chk("bp_v_unwritten", v_mon, 55);
            tick = (j == 3);
            step();
        end
        tick = 0;
        chk("bp_overrun", overrun, 1);
        spike_ready = 1;
        step();
        spike_ready = 0;
        chk("bp_valid_drop", spike_valid, 0);
        chk("bp_v_written", v_mon, -20);
        repeat (2) step();
        chk("bp_done_early", sweep_done, 0);
        step();
        chk("bp_done", sweep_done, 1);
        step();
        chk("bp_idle", busy, 0);

        // Mid-sweep config write to neuron 1 during its EVAL
        do_reset();
        run_sweep(0, 0, 5, 1, -128);
        rd(1, v, vs);
        chk("midcfg_sweep1", v, -11);
        run_sweep(0, 0, 0, 0, 0);
        rd(1, v, vs);
        chk("midcfg_sweep2", v, -39);

        // Reset during a stalled WRITE
        do_reset();
        set_cur(2, 127);
        run_sweep(0, 0, 0, 0, 0);
        run_sweep(0, 0, 0, 0, 0);
        tick = 1; step(); tick = 0;
        repeat (11) step();
        chk("rst_stall_valid", spike_valid, 1);
        rst_n = 0;
        #1;
        chk("rst_stall_valid_drop", spike_valid, 0);
        chk("rst_stall_busy", busy, 0);
        for (int a = 0; a < N; a++) begin
            rd(a, v, vs);
            chk("rst_stall_v", v, -20);
        end
        step();
        rst_n = 1;
        step();
        model_reset();

        // Randomized sweeps against the reference model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(2, 0);
            for (int w = 0; w < nw; w++) begin
                set_cur($urandom_range(N - 1, 0), int'($urandom_range(255, 0)) - 128);
            end
            run_sweep(3, 0, 0, 0, 0);
            model_sweep();
            chk("rnd_nspikes", gspk.size(), mspk.size());
            for (int s = 0; s < mspk.size() && s < gspk.size(); s++) begin
                chk("rnd_spike_id", gspk[s], mspk[s]);
            end
            for (int a = 0; a < N; a++) begin
                rd(a, v, vs);
                chk($sformatf("rnd%0d_v%0d", it, a), v, mV[a]);
            end
        end
        chk("rnd_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
